// File: rtl/light_pkg.sv
// Shared types and default timing constants for the light controller.
package light_pkg;

  typedef enum logic [1:0] {
    AUTO_OFF   = 2'd0,
    AUTO_ON    = 2'd1,
    MANUAL_OFF = 2'd2,
    MANUAL_ON  = 2'd3
  } light_state_t;

  localparam int DEBOUNCE_T_DEFAULT   = 100;
  localparam int LONG_PRESS_T_DEFAULT = 3000;

endpackage

// File: rtl/press_classifier.sv
// Synchronizes and debounces the raw push button, then classifies each
// accepted press as a one-cycle short_press or long_press pulse.
module press_classifier
  import light_pkg::*;
#(
  parameter int DEBOUNCE_T   = DEBOUNCE_T_DEFAULT,
  parameter int LONG_PRESS_T = LONG_PRESS_T_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  output logic short_press,
  output logic long_press
);

  localparam int RW = $clog2(DEBOUNCE_T + 1);
  localparam int HW = $clog2(LONG_PRESS_T + 1);

  logic          sync1;
  logic          sync2;
  logic          db_level;
  logic          armed;
  logic          long_fired;
  logic [1:0]    primed;
  logic [RW-1:0] run_cnt;
  logic [HW-1:0] hold_cnt;

  logic differ;
  logic accept;
  logic fall;
  logic long_hit;

  // Debouncing stays disarmed after reset until the synchronized level has
  // been seen released, so a press held across reset is never classified.
  assign differ   = armed && (sync2 != db_level);
  assign accept   = differ && (run_cnt == RW'(DEBOUNCE_T - 1));
  assign fall     = accept && db_level;
  assign long_hit = db_level && (hold_cnt == HW'(LONG_PRESS_T - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      primed      <= 2'd0;
      armed       <= 1'b0;
      db_level    <= 1'b0;
      run_cnt     <= '0;
      hold_cnt    <= '0;
      long_fired  <= 1'b0;
      long_press  <= 1'b0;
      short_press <= 1'b0;
    end else begin
      sync1 <= push_button;
      sync2 <= sync1;

      // primed reaches 2 once sync2 carries a real post-reset sample
      if (primed != 2'd2)
        primed <= primed + 2'd1;
      if (!armed && (primed == 2'd2) && !sync2)
        armed <= 1'b1;

      if (accept) begin
        db_level <= ~db_level;
        run_cnt  <= '0;
      end else if (differ) begin
        run_cnt <= run_cnt + 1'b1;
      end else begin
        run_cnt <= '0;
      end

      if (!db_level)
        hold_cnt <= '0;
      else if (hold_cnt != HW'(LONG_PRESS_T))
        hold_cnt <= hold_cnt + 1'b1;

      if (!db_level)
        long_fired <= 1'b0;
      else if (long_hit)
        long_fired <= 1'b1;

      long_press  <= long_hit;
      short_press <= fall && !long_fired && !long_hit;
    end
  end

endmodule

// File: rtl/light_controller.sv
// Lamp mode FSM: automatic presence-driven operation or manual button
// toggling, with Moore-decoded lamp, mode and timer-reset outputs.
module light_controller
  import light_pkg::*;
#(
  parameter int DEBOUNCE_T   = DEBOUNCE_T_DEFAULT,
  parameter int LONG_PRESS_T = LONG_PRESS_T_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  input  logic auto_off,
  output logic L,
  output logic modo_manual,
  output logic timer_rst
);

  light_state_t state;
  light_state_t state_next;
  logic         short_press;
  logic         long_press;

  press_classifier #(
    .DEBOUNCE_T  (DEBOUNCE_T),
    .LONG_PRESS_T(LONG_PRESS_T)
  ) u_classifier (
    .clk        (clk),
    .rst        (rst),
    .push_button(push_button),
    .short_press(short_press),
    .long_press (long_press)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= AUTO_OFF;
    else
      state <= state_next;
  end

  // Each branch lists events in priority order: long, short, auto_off, presence.
  always_comb begin
    state_next = state;
    case (state)
      AUTO_OFF: begin
        if (long_press)
          state_next = MANUAL_OFF;
        else if (short_press)
          state_next = AUTO_ON;
        else if (infravermelho)
          state_next = AUTO_ON;
      end
      AUTO_ON: begin
        if (long_press)
          state_next = MANUAL_ON;
        else if (short_press)
          state_next = AUTO_OFF;
        else if (auto_off && !infravermelho)
          state_next = AUTO_OFF;
      end
      MANUAL_OFF: begin
        if (long_press)
          state_next = AUTO_OFF;
        else if (short_press)
          state_next = MANUAL_ON;
      end
      MANUAL_ON: begin
        if (long_press)
          state_next = AUTO_ON;
        else if (short_press)
          state_next = MANUAL_OFF;
      end
      default: state_next = AUTO_OFF;
    endcase
  end

  assign L           = (state == AUTO_ON) || (state == MANUAL_ON);
  assign modo_manual = (state == MANUAL_OFF) || (state == MANUAL_ON);
  assign timer_rst   = (state != AUTO_ON);

endmodule

// File: tb/tb_light_controller.sv
// Directed self-checking bench for light_controller with short debounce and
// long-press times so each scenario completes in a few dozen cycles.
module tb_light_controller;

  logic clk;
  logic rst;
  logic push_button;
  logic infravermelho;
  logic auto_off;
  logic L;
  logic modo_manual;
  logic timer_rst;

  int checks;
  int failures;
  int cyc;
  int short_cnt;
  int long_cnt;
  int long_cyc;
  int press_start;
  int short_base;
  int long_base;

  light_controller #(
    .DEBOUNCE_T  (4),
    .LONG_PRESS_T(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .infravermelho(infravermelho),
    .auto_off     (auto_off),
    .L            (L),
    .modo_manual  (modo_manual),
    .timer_rst    (timer_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts classifier pulses seen at each edge; cyc equals the number of
  // edges elapsed once the edge has been processed.
  always @(posedge clk) begin
    if (dut.u_classifier.short_press)
      short_cnt++;
    if (dut.u_classifier.long_press) begin
      long_cnt++;
      long_cyc = cyc;
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Holds the button for n cycles, releases it and waits for it to settle.
  task automatic applyStimulus(input int n);
    push_button = 1'b1;
    press_start = cyc;
    tick(n);
    push_button = 1'b0;
    tick(12);
  endtask

  task automatic pulseInputs(input logic ir, input logic ao);
    infravermelho = ir;
    auto_off      = ao;
    tick(1);
    infravermelho = 1'b0;
    auto_off      = 1'b0;
  endtask

  task automatic markCounts();
    short_base = short_cnt;
    long_base  = long_cnt;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    short_cnt     = 0;
    long_cnt      = 0;
    long_cyc      = -1;
    rst           = 1'b1;
    push_button   = 1'b0;
    infravermelho = 1'b0;
    auto_off      = 1'b0;

    tick(3);
    checkOutput("reset_L", int'(L), 0);
    checkOutput("reset_modo", int'(modo_manual), 0);
    checkOutput("reset_timer_rst", int'(timer_rst), 1);
    rst = 1'b0;
    tick(5);
    checkOutput("idle_L", int'(L), 0);

    pulseInputs(1'b1, 1'b0);
    checkOutput("ir_on_L", int'(L), 1);
    checkOutput("ir_on_timer_rst", int'(timer_rst), 0);
    tick(1);
    pulseInputs(1'b0, 1'b1);
    checkOutput("auto_off_L", int'(L), 0);
    checkOutput("auto_off_timer_rst", int'(timer_rst), 1);

    markCounts();
    applyStimulus(10);
    checkOutput("short1_L", int'(L), 1);
    checkOutput("short1_modo", int'(modo_manual), 0);
    checkOutput("short1_count", short_cnt - short_base, 1);
    applyStimulus(10);
    checkOutput("short2_L", int'(L), 0);
    checkOutput("short2_modo", int'(modo_manual), 0);
    checkOutput("short2_count", short_cnt - short_base, 2);

    pulseInputs(1'b1, 1'b0);
    tick(1);
    checkOutput("pre_long_L", int'(L), 1);
    markCounts();
    applyStimulus(30);
    checkOutput("long_latency", long_cyc - press_start, 26);
    checkOutput("long_count", long_cnt - long_base, 1);
    checkOutput("long_no_short", short_cnt - short_base, 0);
    checkOutput("manual_on_L", int'(L), 1);
    checkOutput("manual_on_modo", int'(modo_manual), 1);
    checkOutput("manual_on_timer_rst", int'(timer_rst), 1);
    pulseInputs(1'b0, 1'b1);
    tick(1);
    checkOutput("manual_ignores_auto_off", int'(L), 1);

    applyStimulus(30);
    checkOutput("back_auto_on_modo", int'(modo_manual), 0);
    checkOutput("back_auto_on_L", int'(L), 1);
    checkOutput("back_auto_on_timer_rst", int'(timer_rst), 0);
    pulseInputs(1'b1, 1'b1);
    tick(1);
    checkOutput("auto_off_with_ir_L", int'(L), 1);
    pulseInputs(1'b0, 1'b1);
    checkOutput("auto_off_again_L", int'(L), 0);

    applyStimulus(30);
    checkOutput("manual_off_modo", int'(modo_manual), 1);
    checkOutput("manual_off_L", int'(L), 0);
    pulseInputs(1'b1, 1'b0);
    tick(1);
    checkOutput("manual_off_ignores_ir", int'(L), 0);
    applyStimulus(10);
    checkOutput("manual_short_on_L", int'(L), 1);
    checkOutput("manual_short_on_modo", int'(modo_manual), 1);
    applyStimulus(10);
    checkOutput("manual_short_off_L", int'(L), 0);
    applyStimulus(30);
    checkOutput("manual_to_auto_modo", int'(modo_manual), 0);
    checkOutput("manual_to_auto_L", int'(L), 0);

    markCounts();
    applyStimulus(3);
    for (int i = 0; i < 6; i++) begin
      push_button = 1'b1;
      tick(2);
      push_button = 1'b0;
      tick(2);
    end
    tick(10);
    checkOutput("bounce_short", short_cnt - short_base, 0);
    checkOutput("bounce_long", long_cnt - long_base, 0);
    checkOutput("bounce_db", int'(dut.u_classifier.db_level), 0);
    checkOutput("bounce_L", int'(L), 0);

    pulseInputs(1'b1, 1'b0);
    tick(1);
    checkOutput("pre_rst_press_L", int'(L), 1);
    markCounts();
    push_button = 1'b1;
    tick(15);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("mid_rst_L", int'(L), 0);
    checkOutput("mid_rst_timer_rst", int'(timer_rst), 1);
    tick(14);
    push_button = 1'b0;
    tick(15);
    checkOutput("mid_rst_no_short", short_cnt - short_base, 0);
    checkOutput("mid_rst_no_long", long_cnt - long_base, 0);
    checkOutput("mid_rst_final_L", int'(L), 0);
    checkOutput("mid_rst_final_modo", int'(modo_manual), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/light_controller.md
LIGHT_CONTROLLER -- requirements
Module: light_controller

Interface
REQ-001 Parameter DEBOUNCE_T, default 100, is the number of consecutive stable cycles required to accept a button level change.
REQ-002 Parameter LONG_PRESS_T, default 3000, is the held-cycle count at which a press is classified as long.
REQ-003 clk  input  1  is the single system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  is the reset, which is synchronous and active-high.
REQ-005 push_button  input  1  is the raw, asynchronous button level (1 = pressed).
REQ-006 infravermelho  input  1  is the presence sensor level (1 = presence).
REQ-007 auto_off  input  1  is the one-cycle expiry pulse from the auto-shutdown timer.
REQ-008 L  output  1  is the lamp drive (1 = on).
REQ-009 modo_manual  output  1  is the mode indicator (1 = manual, 0 = automatic).
REQ-010 timer_rst  output  1  holds the auto-shutdown timer in reset when 1.

Function
REQ-011 push_button SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debounced level SHALL toggle on the edge where the synchronized level has differed from it for DEBOUNCE_T consecutive cycles; any agreeing cycle clears the run counter.
REQ-013 While the debounced level is 1, a hold counter SHALL increment each cycle, saturating at LONG_PRESS_T; it SHALL clear when the debounced level is 0.
REQ-014 long_press SHALL pulse for exactly one cycle when the hold counter reaches LONG_PRESS_T; it SHALL never repeat within the same press.
REQ-015 short_press SHALL pulse for one cycle on debounced release only if long_press did not fire during that press.
REQ-016 The FSM states SHALL be AUTO_OFF, AUTO_ON, MANUAL_OFF and MANUAL_ON.
REQ-017 The AUTO_OFF transitions SHALL be: long_press -> MANUAL_OFF; short_press -> AUTO_ON; infravermelho=1 -> AUTO_ON.
REQ-018 The AUTO_ON transitions SHALL be: long_press -> MANUAL_ON; short_press -> AUTO_OFF; auto_off=1 with infravermelho=0 -> AUTO_OFF.
REQ-019 The MANUAL_OFF transitions SHALL be: long_press -> AUTO_OFF; short_press -> MANUAL_ON; infravermelho and auto_off are ignored.
REQ-020 The MANUAL_ON transitions SHALL be: long_press -> AUTO_ON; short_press -> MANUAL_OFF; infravermelho and auto_off are ignored.
REQ-021 Event priority in any state SHALL be long_press > short_press > auto_off > infravermelho.
REQ-022 auto_off coincident with infravermelho=1 SHALL be ignored, so the lamp stays in AUTO_ON.
REQ-023 The outputs SHALL be Moore outputs decoded from the state register:
- L = 1 in AUTO_ON and MANUAL_ON;
- modo_manual = 1 in MANUAL_*;
- timer_rst = 0 only in AUTO_ON.
REQ-024 Latency from an event sampled at edge n to the output change SHALL be exactly one cycle (the output is valid after edge n+1).
REQ-025 Latency from a raw button edge to the debounced change SHALL be 2 + DEBOUNCE_T cycles.
REQ-026 Counter widths SHALL be $clog2(param+1); no counter may wrap.

Reset
REQ-027 On rst=1 at a clock edge, the state SHALL become AUTO_OFF and the synchronizer, debounced level, run counter, hold counter and pulses SHALL clear to 0.
REQ-028 During and after reset the outputs SHALL be L=0, modo_manual=0, timer_rst=1.
REQ-029 A reset asserted mid-press SHALL discard the press; no short_press or long_press may result from it.

Structure
REQ-030 The package light_pkg SHALL hold the state enum (light_state_t) and the default constants for DEBOUNCE_T and LONG_PRESS_T.
REQ-031 Synchronization, debounce and press classification SHALL reside in the sub-module press_classifier, which outputs short_press and long_press.
REQ-032 The light_controller top level SHALL contain only the FSM and output decode.

Verification (DEBOUNCE_T=4, LONG_PRESS_T=20)
REQ-033 Reset then infravermelho=1 for 1 cycle -> L=1 and timer_rst=0 one cycle later; a subsequent auto_off pulse -> L=0 and timer_rst=1.
REQ-034 A 10-cycle press -> one short_press on release, toggling L 0->1; a second 10-cycle press -> L=0; modo_manual stays 0.
REQ-035 A 30-cycle press from AUTO_ON -> long_press 26 cycles after the press edge, state MANUAL_ON, modo_manual=1, L=1, no short_press at release; subsequent auto_off is ignored.
REQ-036 A 3-cycle glitch or alternating bounce every 2 cycles -> no debounced change and no pulses.
REQ-037 auto_off and infravermelho=1 in the same cycle in AUTO_ON -> L stays 1.
REQ-038 rst asserted at cycle 15 of a 30-cycle press -> state AUTO_OFF, no long_press, no short_press after release.
